// File: rtl/ram_access_ctrl_if.sv
// Client-side handshake bundle for ram_access_ctrl:
// write/read requests, held read response, bulk clear.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              clr_req;
  logic              busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output clr_req, wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr, rsp_ready,
    input  busy, wr_ready, rd_ready,
    input  rsp_valid, rsp_data
  );

  modport slave (
    input  clr_req, wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr, rsp_ready,
    output busy, wr_ready, rd_ready,
    output rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Serializes write/read/clear requests onto a single-port
// synchronous RAM and holds read results until consumed.
module ram_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  ram_access_ctrl_if.slave  bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_CAPT, RSP, CLEAR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              idle;
  logic              wr_acc;
  logic              rd_acc;

  assign idle         = (state_q == IDLE);
  assign bus.wr_ready = idle & ~bus.clr_req;
  assign bus.rd_ready = idle & ~bus.clr_req & ~bus.wr_valid;
  assign bus.busy     = ~idle;
  assign wr_acc       = bus.wr_valid & bus.wr_ready;
  assign rd_acc       = bus.rd_valid & bus.rd_ready;

  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = '0;
        end else if (wr_acc) begin
          state_d    = WRITE;
          ram_we_d   = 1'b1;
          ram_addr_d = bus.wr_addr;
          ram_din_d  = bus.wr_data;
        end else if (rd_acc) begin
          state_d    = RD_ISSUE;
          ram_we_d   = 1'b0;
          ram_addr_d = bus.rd_addr;
        end
      end
      WRITE: begin
        state_d  = IDLE;
        ram_we_d = 1'b0;
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = ram_dout;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      CLEAR: begin
        // counter tracks the address being written this cycle
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          ram_we_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ram_addr_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request sequencer that sits directly upstream of `single_port_ram` (16 x 8, one shared address port) and owns its `we`/`addr`/`din` pins. It accepts independent write and read requests over valid/ready handshakes, serializes them onto the single RAM port, captures read data into a held response channel, and provides a bulk-clear command that zeroes every location. Clients never drive the RAM directly.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 8: RAM data width.
- `DEPTH`, 2**ADDR_W: locations swept by clear.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr_req`  in  1  start bulk clear. Sampled only in IDLE.
- `busy`  out  1  high whenever state != IDLE.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  write accepted this cycle when `wr_valid & wr_ready`.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_valid`  in  1  read request present.
- `rd_ready`  out  1  read accepted this cycle when `rd_valid & rd_ready`.
- `rd_addr`  in  ADDR_W  read address.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes `rsp_data`.
- `rsp_data`  out  DATA_W  read result.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_din`  out  DATA_W  to RAM `din`.
- `ram_dout`  in  DATA_W  from RAM `dout`. The RAM writes on the clock edge ending a cycle with `we=1`. Its read is synchronous: `dout` is valid the cycle after `addr` is presented with `we=0`.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_CAPT, RSP, CLEAR.
- `wr_ready = (state==IDLE) & !clr_req`.
- `rd_ready = (state==IDLE) & !clr_req & !wr_valid`.
- Priority in IDLE: clear > write > read.
- IDLE -> CLEAR when `clr_req`. Load the clear counter with 0.
- IDLE -> WRITE on write accept. Register `ram_addr<=wr_addr`, `ram_din<=wr_data`, `ram_we<=1`.
- WRITE lasts 1 cycle, then returns to IDLE with `ram_we<=0`.
- IDLE -> RD_ISSUE on read accept. Register `ram_addr<=rd_addr` with `ram_we=0`.
- RD_ISSUE -> RD_CAPT unconditionally.
- RD_CAPT -> RSP, registering `rsp_data<=ram_dout` and `rsp_valid<=1`.
- RSP holds `rsp_valid` and `rsp_data` stable until `rsp_ready`. On that edge `rsp_valid<=0` and the state returns to IDLE. No new request is accepted while in RSP.
- CLEAR drives `ram_we=1` and `ram_din=0`. `ram_addr` steps 0,1,...,DEPTH-1, one location per cycle. After location DEPTH-1 is written, the counter wraps to 0, `ram_we<=0`, and the state returns to IDLE.
- `clr_req`, `wr_valid` and `rd_valid` outside IDLE are ignored, not queued. Requesters must hold valid until ready.
- All `ram_*` outputs and `rsp_*` outputs are registered. There is no combinational path from any input to `ram_*`.
- Addresses are used modulo DEPTH. There is no out-of-range checking.

## Timing
- Reset: state IDLE. `busy`, `ram_we`, `rsp_valid` = 0. `ram_addr`, `ram_din`, `rsp_data` = 0. The clear counter = 0.
- Reset mid-operation: an in-flight write or clear is aborted, a pending response is dropped, and RAM contents are left as-is.
- Write: accept at edge E. `ram_we` is high during cycle E+1 and the RAM stores at edge E+1. `wr_ready` is high again in cycle E+2. Sustained throughput is 1 write per 2 cycles.
- Read: accept at edge E. `rsp_valid` rises at edge E+2.
  - If `rsp_ready` is held high, the response is taken at edge E+3 and the next request can be accepted at edge E+4.
  - A read accepted the cycle after a write to the same address returns the new data.
- Clear: `clr_req` seen at edge E. Writes occur at edges E+1..E+DEPTH. IDLE resumes and `busy` falls at edge E+DEPTH.
- `busy` rises on the same edge the FSM leaves IDLE.

## Test plan
- After reset, check `rsp_valid=0`, `ram_we=0`, `busy=0`. Then write 15@0, 25@1, 35@2 with `wr_valid` held -> exactly three one-cycle `ram_we` pulses carrying addr 0/1/2 with din 15/25/35.
- Read addr 0, 1, 2 -> `rsp_data` = 15, 25, 35. Each `rsp_valid` rises 2 edges after accept.
- Read addr 1 with `rsp_ready=0` for 5 cycles -> `rsp_valid` stays high, `rsp_data` stays 25, and `wr_ready`/`rd_ready` stay 0. Raising `rsp_ready` retires the response in 1 edge.
- Assert `clr_req`, `wr_valid` and `rd_valid` in the same IDLE cycle -> clear wins and both readies are 0. 16 writes of 0 to addr 0..15, `busy` high for 16 cycles. A subsequent read of addr 2 -> 0.
- Hold `wr_valid` and `rd_valid` together -> the write is accepted first and the read is accepted on the next IDLE cycle. A read of the just-written address returns the new value.
- Assert `rst` at clear step 7 -> IDLE next edge with `ram_we=0`. Locations 0..6 = 0 and locations 7..15 keep their old data.
